// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM encoding, default character width,
// parity modes and the parity helper.
package uart_pkg;

   localparam int DATA_BITS_DEF = 8;

   typedef enum logic {
      PARITY_EVEN = 1'b0,
      PARITY_ODD  = 1'b1
   } parity_mode_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_LOAD   = 3'd2,
      ST_START  = 3'd3,
      ST_DATA   = 3'd4,
      ST_PARITY = 3'd5,
      ST_STOP   = 3'd6
   } tx_state_e;

   // data_xor is the XOR reduction of the character bits
   function automatic logic parity_bit(input logic data_xor, input parity_mode_e mode);
      return (mode == PARITY_ODD) ? ~data_xor : data_xor;
   endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period down-counter: reloads the divisor on load and at every bit end,
// and flags the last cycle of each bit period.
module uart_baud_counter #(
   parameter int DIV_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load,
   input  logic                 run,
   input  logic [DIV_WIDTH-1:0] div,
   output logic                 bit_end
);

   logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d   = cnt_q;
      bit_end = run && (cnt_q == '0);
      if (load) begin
         cnt_d = div;
      end else if (run) begin
         cnt_d = bit_end ? div : cnt_q - DIV_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx_sequencer.sv
// UART transmit sequencer: pops one byte per character from the TX FIFO and
// serializes start, data (LSB first), optional parity and 1/2 stop bits on txd.
module uart_tx_sequencer
   import uart_pkg::*;
#(
   parameter int DATA_BITS = DATA_BITS_DEF,
   parameter int DIV_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [DIV_WIDTH-1:0] baud_div,
   input  logic                 parity_en,
   input  logic                 parity_odd,
   input  logic                 stop2,
   input  logic                 fifo_empty,
   output logic                 fifo_rd_en,
   input  logic [DATA_BITS-1:0] fifo_data,
   output logic                 txd,
   output logic                 busy,
   output logic                 tx_done
);

   localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

   tx_state_e            state_q, state_d;
   logic                 txd_q, txd_d;
   logic                 fifo_rd_en_q, fifo_rd_en_d;
   logic                 tx_done_q, tx_done_d;
   logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic                 stop_cnt_q, stop_cnt_d;

   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 parity_q, parity_d;
   logic                 par_en_q, par_en_d;
   logic                 stop2_q, stop2_d;
   logic [DIV_WIDTH-1:0] div_q, div_d;

   logic                 baud_load;
   logic                 baud_run;
   logic [DIV_WIDTH-1:0] baud_div_sel;
   logic                 bit_end;

   // The divisor is latched during LOAD, so the counter takes the live value then.
   assign baud_load    = (state_q == ST_LOAD);
   assign baud_run     = (state_q == ST_START) || (state_q == ST_DATA) ||
                         (state_q == ST_PARITY) || (state_q == ST_STOP);
   assign baud_div_sel = baud_load ? baud_div : div_q;

   uart_baud_counter #(
      .DIV_WIDTH (DIV_WIDTH)
   ) u_baud (
      .clk     (clk),
      .reset   (reset),
      .load    (baud_load),
      .run     (baud_run),
      .div     (baud_div_sel),
      .bit_end (bit_end)
   );

   // txd_d always carries the level of the bit that begins next cycle.
   always_comb begin
      state_d      = state_q;
      txd_d        = txd_q;
      fifo_rd_en_d = 1'b0;
      tx_done_d    = 1'b0;
      bit_cnt_d    = bit_cnt_q;
      stop_cnt_d   = stop_cnt_q;
      shift_d      = shift_q;
      parity_d     = parity_q;
      par_en_d     = par_en_q;
      stop2_d      = stop2_q;
      div_d        = div_q;

      case (state_q)
         ST_IDLE: begin
            txd_d = 1'b1;
            if (enable && !fifo_empty) begin
               state_d      = ST_FETCH;
               fifo_rd_en_d = 1'b1;
            end
         end
         ST_FETCH: begin
            state_d = ST_LOAD;
         end
         ST_LOAD: begin
            shift_d    = fifo_data;
            div_d      = baud_div;
            par_en_d   = parity_en;
            stop2_d    = stop2;
            parity_d   = parity_bit(^fifo_data, parity_mode_e'(parity_odd));
            bit_cnt_d  = '0;
            stop_cnt_d = 1'b0;
            state_d    = ST_START;
            txd_d      = 1'b0;
         end
         ST_START: begin
            if (bit_end) begin
               state_d = ST_DATA;
               txd_d   = shift_q[0];
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               shift_d = shift_q >> 1;
               if (bit_cnt_q == LAST_BIT) begin
                  bit_cnt_d = '0;
                  if (par_en_q) begin
                     state_d = ST_PARITY;
                     txd_d   = parity_q;
                  end else begin
                     state_d = ST_STOP;
                     txd_d   = 1'b1;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
                  txd_d     = shift_d[0];
               end
            end
         end
         ST_PARITY: begin
            if (bit_end) begin
               state_d = ST_STOP;
               txd_d   = 1'b1;
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               if (stop2_q && !stop_cnt_q) begin
                  stop_cnt_d = 1'b1;
               end else begin
                  stop_cnt_d = 1'b0;
                  state_d    = ST_IDLE;
                  tx_done_d  = 1'b1;
                  txd_d      = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            txd_d   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         txd_q        <= 1'b1;
         fifo_rd_en_q <= 1'b0;
         tx_done_q    <= 1'b0;
         bit_cnt_q    <= '0;
         stop_cnt_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         txd_q        <= txd_d;
         fifo_rd_en_q <= fifo_rd_en_d;
         tx_done_q    <= tx_done_d;
         bit_cnt_q    <= bit_cnt_d;
         stop_cnt_q   <= stop_cnt_d;
      end
   end

   // Character data and per-frame configuration are always rewritten in LOAD.
   always_ff @(posedge clk) begin
      shift_q  <= shift_d;
      parity_q <= parity_d;
      par_en_q <= par_en_d;
      stop2_q  <= stop2_d;
      div_q    <= div_d;
   end

   assign txd        = txd_q;
   assign fifo_rd_en = fifo_rd_en_q;
   assign tx_done    = tx_done_q;
   assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Directed bench for uart_tx_sequencer with a small FIFO model and per-frame
// bit capture against hand-computed frame vectors.
module tb_uart_tx_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [15:0] baud_div;
   logic        parity_en;
   logic        parity_odd;
   logic        stop2;
   logic        fifo_empty;
   logic        fifo_rd_en;
   logic [7:0]  fifo_data;
   logic        txd;
   logic        busy;
   logic        tx_done;

   logic [7:0]  mem [0:15];
   int          wp = 0;
   int          rp = 0;

   int compared   = 0;
   int mismatched = 0;
   int rd_cnt     = 0;
   int done_cnt   = 0;

   uart_tx_sequencer #(
      .DATA_BITS (8),
      .DIV_WIDTH (16)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .baud_div   (baud_div),
      .parity_en  (parity_en),
      .parity_odd (parity_odd),
      .stop2      (stop2),
      .fifo_empty (fifo_empty),
      .fifo_rd_en (fifo_rd_en),
      .fifo_data  (fifo_data),
      .txd        (txd),
      .busy       (busy),
      .tx_done    (tx_done)
   );

   always #5 clk = ~clk;

   assign fifo_empty = (wp == rp);

   always @(posedge clk) begin
      if (fifo_rd_en && (wp != rp)) begin
         fifo_data <= mem[rp % 16];
         rp        <= rp + 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (fifo_rd_en === 1'b1) rd_cnt++;
      if (tx_done === 1'b1) done_cnt++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      mem[wp % 16] = b;
      wp = wp + 1;
   endtask

   task automatic wait_start(input string tag);
      int n;
      n = 0;
      while (txd !== 1'b0 && n < 300) begin
         tick();
         n++;
      end
      chk(tag, {31'd0, txd}, 32'd0);
   endtask

   // Assumes the current sample is the first cycle of the start bit.
   task automatic get_frame(input int nbits, input int cpb,
                            output logic [15:0] bits, output logic stable);
      logic v;
      bits   = '0;
      stable = 1'b1;
      for (int i = 0; i < nbits; i++) begin
         for (int c = 0; c < cpb; c++) begin
            if (i != 0 || c != 0) tick();
            v = txd;
            if (c == 0) bits[i] = v;
            else if (v !== bits[i]) stable = 1'b0;
         end
      end
   endtask

   task automatic run_frame(input string tag, input int nbits, input int cpb,
                            input logic [15:0] exp);
      logic [15:0] bits;
      logic        stable;
      wait_start({tag, "_start"});
      get_frame(nbits, cpb, bits, stable);
      chk({tag, "_bits"}, {16'd0, bits}, {16'd0, exp});
      chk({tag, "_stable"}, {31'd0, stable}, 32'd1);
      tick();
      chk({tag, "_done"}, {31'd0, tx_done}, 32'd1);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      logic [15:0] bits;
      logic        stable;
      int          r0, d0, gap;

      reset      = 1'b1;
      enable     = 1'b0;
      baud_div   = 16'd3;
      parity_en  = 1'b0;
      parity_odd = 1'b0;
      stop2      = 1'b0;
      fifo_data  = 8'h00;
      repeat (2) tick();
      chk("rst_txd", {31'd0, txd}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, tx_done}, 32'd0);
      chk("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
      reset = 1'b0;

      // Disabled with data waiting, then enable and check latency
      push(8'h55);
      repeat (5) tick();
      chk("dis_rd_cnt", rd_cnt, 32'd0);
      chk("dis_txd", {31'd0, txd}, 32'd1);
      chk("dis_busy", {31'd0, busy}, 32'd0);
      enable = 1'b1;
      tick();
      chk("lat_fetch_rd", {31'd0, fifo_rd_en}, 32'd1);
      chk("lat_fetch_busy", {31'd0, busy}, 32'd1);
      tick();
      chk("lat_load_rd", {31'd0, fifo_rd_en}, 32'd0);
      chk("lat_load_txd", {31'd0, txd}, 32'd1);
      tick();
      chk("lat_start_txd", {31'd0, txd}, 32'd0);
      get_frame(10, 4, bits, stable);
      chk("f55_bits", {16'd0, bits}, 32'h2AA);
      chk("f55_stable", {31'd0, stable}, 32'd1);
      tick();
      chk("f55_done", {31'd0, tx_done}, 32'd1);
      chk("f55_busy", {31'd0, busy}, 32'd0);
      repeat (5) tick();
      chk("f55_rd_cnt", rd_cnt, 32'd1);
      chk("f55_done_cnt", done_cnt, 32'd1);

      // Parity: 0x03 has XOR 0
      parity_en  = 1'b1;
      parity_odd = 1'b0;
      stop2      = 1'b1;
      baud_div   = 16'd1;
      push(8'h03);
      run_frame("par_even_stop2", 12, 2, 16'hC06);
      parity_odd = 1'b1;
      stop2      = 1'b0;
      push(8'h03);
      run_frame("par_odd", 11, 2, 16'h606);

      // Back-to-back at one cycle per bit
      parity_en = 1'b0;
      baud_div  = 16'd0;
      r0 = rd_cnt;
      d0 = done_cnt;
      push(8'hA5);
      push(8'h3C);
      run_frame("b2b_a5", 10, 1, 16'h34A);
      gap = 0;
      while (txd === 1'b1 && gap < 20) begin
         gap++;
         tick();
      end
      chk("b2b_gap", gap, 32'd3);
      run_frame("b2b_3c", 10, 1, 16'h278);
      repeat (5) tick();
      chk("b2b_rd_cnt", rd_cnt - r0, 32'd2);
      chk("b2b_done_cnt", done_cnt - d0, 32'd2);

      // Asynchronous reset in the third data bit
      baud_div = 16'd3;
      push(8'h00);
      wait_start("rstmid_start");
      repeat (13) tick();
      chk("rstmid_pre_txd", {31'd0, txd}, 32'd0);
      chk("rstmid_pre_busy", {31'd0, busy}, 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("rstmid_txd", {31'd0, txd}, 32'd1);
      chk("rstmid_busy", {31'd0, busy}, 32'd0);
      chk("rstmid_done", {31'd0, tx_done}, 32'd0);
      tick();
      reset = 1'b0;
      push(8'h55);
      run_frame("after_rst", 10, 4, 16'h2AA);

      // Divisor change mid-frame takes effect on the next character
      push(8'h55);
      push(8'h55);
      wait_start("baud_chg_start");
      baud_div = 16'd7;
      get_frame(10, 4, bits, stable);
      chk("baud4_bits", {16'd0, bits}, 32'h2AA);
      chk("baud4_stable", {31'd0, stable}, 32'd1);
      tick();
      chk("baud4_done", {31'd0, tx_done}, 32'd1);
      run_frame("baud8", 10, 8, 16'h2AA);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/uart_tx_sequencer.md
# uart_tx_sequencer

Transmit-side controller of the UART. It drains bytes from the transmit FIFO with a read-enable handshake and serializes each byte onto `txd` as a framed asynchronous character: start bit, 8 data bits LSB first, optional parity, and 1 or 2 stop bits. Frame format and bit period come from APB-programmed configuration registers and are latched per character.

## Interface
Parameters:
- `DATA_BITS`, 8: character width.
- `DIV_WIDTH`, 16: width of the baud divisor.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  reset, asynchronous, active-high
- `enable`  in  1  transmitter enable from control register
- `baud_div`  in  DIV_WIDTH  bit period minus one, in clk cycles
- `parity_en`  in  1  append parity bit
- `parity_odd`  in  1  1 = odd parity, 0 = even parity
- `stop2`  in  1  1 = two stop bits, 0 = one stop bit
- `fifo_empty`  in  1  TX FIFO empty flag
- `fifo_rd_en`  out  1  pop request to the TX FIFO
- `fifo_data`  in  DATA_BITS  FIFO read data, valid the cycle after `fifo_rd_en`
- `txd`  out  1  serial output, idle high
- `busy`  out  1  character in progress
- `tx_done`  out  1  one-cycle pulse at the end of each character

## Operation
- FSM states: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- IDLE: if `enable && !fifo_empty`, go to FETCH. Otherwise stay in IDLE.
- FETCH: `fifo_rd_en`=1 for exactly this cycle. Always go to LOAD.
- LOAD:
  - Capture `fifo_data` into the shift register.
  - Latch `baud_div`, `parity_en`, `parity_odd`, `stop2`.
  - Compute parity: even parity = XOR of the data bits; odd parity = the inverse of that XOR.
  - Clear the bit counter and go to START.
- START: `txd`=0 for one bit period, then go to DATA.
- DATA: drive `txd` = shift[0] and shift right at each bit end. After DATA_BITS bits, go to PARITY if `parity_en`, else go to STOP.
- PARITY: drive `txd` = the parity bit for one bit period.
- STOP: `txd`=1 for 1 bit period, or 2 if `stop2`. Then go to IDLE and pulse `tx_done`.
- Configuration changes during a character have no effect until the next LOAD.
- Deasserting `enable` mid-character lets the current frame complete. No further FETCH occurs.
- `fifo_empty` is sampled only in IDLE.
- Outputs are registered; `busy` = (state != IDLE).

## Timing
- Reset values: `txd`=1, `fifo_rd_en`=0, `busy`=0, `tx_done`=0, state IDLE, all counters 0.
- Reset takes effect immediately (asynchronous). If asserted mid-frame, the frame is abandoned and `txd` returns high at once. No partial resumption.
- Each bit lasts exactly `baud_div`+1 cycles. `baud_div`=0 gives 1 cycle per bit.
- Latency:
  - Cycle T: IDLE sees the start condition.
  - T+1: FETCH (`fifo_rd_en`=1).
  - T+2: LOAD.
  - T+3: first cycle with `txd`=0.
- Frame length = (1 + DATA_BITS + parity_en + 1 + stop2) × (`baud_div`+1) cycles.
- `tx_done` is high in the first IDLE cycle after the last stop-bit cycle; `busy` is 0 in that same cycle.
- Back-to-back characters: 3 extra `txd`-high cycles between frames (IDLE, FETCH, LOAD), which appear as extended stop time.
- Baud counter width is DIV_WIDTH; it reloads on every bit end and never wraps mid-bit.

## Structure
- Shared package `uart_pkg`: FSM state encoding, `DATA_BITS` default, parity-mode constants.
- Sub-module `uart_baud_counter`:
  - Loads the latched divisor on LOAD and on each bit end.
  - Counts down and emits a one-cycle `bit_end` pulse when the count reaches 0.
- The FSM, shift register and bit/stop counters stay in `uart_tx_sequencer`.

## Test plan
- `baud_div`=3, no parity, 1 stop, FIFO holds 0x55:
  - one `fifo_rd_en` pulse;
  - `txd` = 0,1,0,1,0,1,0,1,0,1, each held 4 cycles (40 cycles total);
  - exactly one `tx_done` pulse.
- `parity_en`=1 with 0x03: even parity gives a parity bit of 0; odd parity gives 1. Frame is 11 bits. With `stop2`=1, `txd` is high for 2 bit periods before `tx_done`.
- FIFO holds 0xA5 then 0x3C, `baud_div`=0:
  - two `fifo_rd_en` pulses;
  - frames are serialized LSB first;
  - exactly 3 high cycles between the last stop bit of the first frame and the second start bit.
- `enable`=0 with FIFO non-empty: `fifo_rd_en` never asserts and `txd` stays 1. Raising `enable` gives `fifo_rd_en` 1 cycle later.
- Reset asserted during the 3rd data bit: `txd`=1, `busy`=0 and `tx_done`=0 immediately. After release, a new character starts with a fresh start bit.
- Changing `baud_div` from 3 to 7 mid-frame: the current frame keeps 4-cycle bits; the next frame uses 8-cycle bits.
